degamma_search: RTL and testbench

- Inverse gamma engine: converts a gamma-corrected colour value back to its linear code.
- Drives the address port of a registered forward gamma LUT (the gamma_table block: one-cycle read latency, monotonic non-decreasing curve) and binary-searches it.
- Result: the largest linear code x such that lut(x) <= target.
- Sits between the pixel input stream and the linear-domain processing. Ready/valid handshakes on both sides.

---
 rtl/degamma_search_if.sv | 31 +++
 rtl/degamma_search.sv | 111 +++++++++++
 tb/tb_degamma_search.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/degamma_search_if.sv
`default_nettype none
// ============================================================================
//  Module      : degamma_search_if
//  Description : Target/result handshakes and forward-LUT port for degamma_search.
//  Revision    : 1.0
// ============================================================================
interface degamma_search_if #(
    parameter int COLOR_RES = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [COLOR_RES-1:0] in_val;
    logic                 out_valid;
    logic                 out_ready;
    logic [COLOR_RES-1:0] out_val;
    logic [COLOR_RES-1:0] lut_addr;
    logic [COLOR_RES-1:0] lut_data;
    logic                 busy;

    // master: pixel source, result sink and forward LUT around the engine
    modport master (
        output in_valid, in_val, out_ready, lut_data,
        input  in_ready, out_valid, out_val, lut_addr, busy
    );

    modport slave (
        input  in_valid, in_val, out_ready, lut_data,
        output in_ready, out_valid, out_val, lut_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/degamma_search.sv
`default_nettype none
// ============================================================================
//  Module      : degamma_search
//  Description : Inverse gamma by binary search of a registered forward LUT.
//  Revision    : 1.0
// ============================================================================
module degamma_search #(
    parameter int COLOR_RES = 8
) (
    input  logic              clk,
    input  logic              rst,
    degamma_search_if.slave   bus
);

    localparam int                   c_BIT_W   = (COLOR_RES > 1) ? $clog2(COLOR_RES) : 1;
    localparam logic [c_BIT_W-1:0]   c_TOP_BIT = c_BIT_W'(COLOR_RES - 1);
    localparam logic [COLOR_RES-1:0] c_ONE     = COLOR_RES'(1);
    localparam logic [COLOR_RES-1:0] c_MSB     = c_ONE << (COLOR_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_CMP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [COLOR_RES-1:0] r_x;
    logic [c_BIT_W-1:0]   r_bit;
    logic [COLOR_RES-1:0] r_target;
    logic [COLOR_RES-1:0] r_lut_addr;
    logic [COLOR_RES-1:0] r_out_val;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;

    logic                 w_hit;
    logic [COLOR_RES-1:0] w_x_next;
    logic [c_BIT_W-1:0]   w_bit_dec;
    logic [COLOR_RES-1:0] w_next_probe;

    // The probed address only ever adds a bit below those already decided,
    // so OR-ing it onto the running x never carries.
    assign w_hit        = (bus.lut_data <= r_target);
    assign w_x_next     = w_hit ? r_lut_addr : r_x;
    assign w_bit_dec    = r_bit - 1'b1;
    assign w_next_probe = w_x_next | (c_ONE << w_bit_dec);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_bit       <= c_TOP_BIT;
            r_target    <= '0;
            r_lut_addr  <= '0;
            r_out_val   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_target   <= bus.in_val;
                        r_x        <= '0;
                        r_bit      <= c_TOP_BIT;
                        r_lut_addr <= c_MSB;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_PROBE;
                    end
                end
                // LUT samples r_lut_addr at the end of this cycle
                S_PROBE: begin
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    r_x <= w_x_next;
                    if (r_bit == '0) begin
                        r_out_val   <= w_x_next;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_bit      <= w_bit_dec;
                        r_lut_addr <= w_next_probe;
                        r_state    <= S_PROBE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_val   = r_out_val;
    assign bus.lut_addr  = r_lut_addr;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_degamma_search.sv
`default_nettype none
// ============================================================================
//  Module      : tb_degamma_search
//  Description : Directed bench with a reference model for degamma_search.
//  Revision    : 1.0
// ============================================================================
module tb_degamma_search;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   lut_mode = 0;

    always #5 clk = ~clk;

    degamma_search_if #(.COLOR_RES(N)) bus ();

    degamma_search #(.COLOR_RES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // 0: identity, 1: half, 2: step at 128, 3: saturated at 255
    function automatic int lut_fn(input int mode, input int x);
        case (mode)
            0:       return x;
            1:       return x >> 1;
            2:       return (x < 128) ? 0 : 255;
            default: return 255;
        endcase
    endfunction

    function automatic int ref_result(input int mode, input int t);
        for (int x = (1 << N) - 1; x > 0; x--)
            if (lut_fn(mode, x) <= t) return x;
        return 0;
    endfunction

    always @(posedge clk) bus.lut_data <= N'(lut_fn(lut_mode, int'(bus.lut_addr)));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model and per-cycle compare ----------------
    int   nedge = 0, n_acc = 0, last_lat = -1, n_taken = 0;
    logic prev_ov = 1'b0;
    int   m_busy = 0, m_done = 0, m_cnt = 0, m_res = 0, m_outv = 0, m_addr = 0;
    int   m_probes [N];
    int   lit_q [$];
    int   acc_q [$];

    always @(negedge clk) begin
        int x, p, lit;
        nedge++;
        chk("in_ready",  int'(bus.in_ready),  (m_busy == 0 && m_done == 0) ? 1 : 0);
        chk("out_valid", int'(bus.out_valid), m_done);
        chk("busy",      int'(bus.busy),      m_busy);
        chk("out_val",   int'(bus.out_val),   m_outv);
        chk("lut_addr",  int'(bus.lut_addr),  m_addr);
        if (bus.out_valid && !prev_ov) last_lat = nedge - n_acc - 1;
        prev_ov = bus.out_valid;

        if (rst) begin
            m_busy = 0; m_done = 0; m_outv = 0; m_addr = 0; m_cnt = 0;
        end else if (m_busy == 0 && m_done == 0 && bus.in_valid) begin
            m_busy = 1; m_cnt = 0;
            m_res  = ref_result(lut_mode, int'(bus.in_val));
            x = 0;
            for (int b = N - 1; b >= 0; b--) begin
                p = x | (1 << b);
                m_probes[N - 1 - b] = p;
                if (lut_fn(lut_mode, p) <= int'(bus.in_val)) x = p;
            end
            m_addr = m_probes[0];
            n_acc  = nedge;
            acc_q.push_back(nedge);
        end else if (m_busy != 0) begin
            m_cnt++;
            if (m_cnt == 2 * N) begin
                m_busy = 0; m_done = 1; m_outv = m_res;
            end else begin
                m_addr = m_probes[m_cnt / 2];
            end
        end else if (m_done != 0 && bus.out_ready) begin
            m_done = 0;
            n_taken++;
            if (lit_q.size() > 0) begin
                lit = lit_q.pop_front();
                chk("result_literal", int'(bus.out_val), lit);
                chk("model_literal",  m_res, lit);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int t);
        int b;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_val   = N'(t);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!bus.in_ready && b < 200);
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_taken(input int n);
        int b;
        b = 0;
        while (n_taken < n && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (n_taken < n) chk("take_timeout", n_taken, n);
    endtask

    task automatic run(input int mode, input int t, input int exp, input bit chk_lat);
        int k;
        lut_mode = mode;
        k = n_taken + 1;
        lit_q.push_back(exp);
        send(t);
        wait_taken(k);
        if (chk_lat) chk("latency", last_lat, 2 * N);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int id_t [5];
        int pr_exp [8];
        int bb_t [4];
        int a0, k;
        id_t   = '{0, 1, 128, 200, 255};
        pr_exp = '{128, 64, 32, 48, 56, 52, 50, 51};
        bb_t   = '{10, 255, 0, 50};

        bus.in_valid  = 1'b0;
        bus.in_val    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  int'(bus.in_ready),  1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_val",   int'(bus.out_val),   0);
        chk("rst_lut_addr",  int'(bus.lut_addr),  0);
        chk("rst_busy",      int'(bus.busy),      0);

        foreach (id_t[i]) run(0, id_t[i], id_t[i], 1'b1);
        run(1, 10, 21, 1'b0);
        run(1, 127, 255, 1'b0);
        run(1, 0, 1, 1'b0);
        run(2, 100, 127, 1'b0);
        run(2, 255, 255, 1'b0);
        run(3, 0, 0, 1'b0);

        // backpressure: result held while the sink stalls, new targets ignored
        lut_mode = 0;
        bus.out_ready = 1'b0;
        k = n_taken + 1;
        lit_q.push_back(128);
        send(128);
        a0 = 0;
        while (!bus.out_valid && a0 < 40) begin
            @(negedge clk);
            a0++;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_val   = N'(7);
            @(negedge clk);
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_out_val",   int'(bus.out_val),   128);
            chk("bp_in_ready",  int'(bus.in_ready),  0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_taken(k);
        @(negedge clk);
        chk("bp_idle_in_ready",  int'(bus.in_ready),  1);
        chk("bp_idle_out_valid", int'(bus.out_valid), 0);

        // reset during the fifth compare cycle
        send(200);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_busy", int'(bus.busy), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready",  int'(bus.in_ready),  1);
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_lut_addr",  int'(bus.lut_addr),  0);
        chk("mid_rst_busy",      int'(bus.busy),      0);
        run(0, 50, 50, 1'b1);

        // back-to-back stream, probe sequence captured for the last target
        lut_mode = 0;
        a0 = acc_q.size();
        k  = n_taken + 4;
        foreach (bb_t[i]) begin
            lit_q.push_back(bb_t[i]);
            send(bb_t[i]);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("probe_seq", int'(bus.lut_addr), pr_exp[i]);
            @(negedge clk);
        end
        wait_taken(k);
        if (acc_q.size() >= a0 + 4) begin
            for (int i = 1; i < 4; i++)
                chk("accept_spacing", acc_q[a0 + i] - acc_q[a0 + i - 1], 2 * N + 2);
        end else begin
            chk("accept_count", acc_q.size() - a0, 4);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
